// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder.
//   state_t  : responder FSM states
//   WORD_W, ADDR_W, MEM_DEPTH, MAX_WAIT : default geometry and wait-state limit
//   sat_inc  : 16-bit saturating increment used by the optional statistics counters
package mem_pkg;
   localparam int WORD_W    = 12;
   localparam int ADDR_W    = 6;
   localparam int MEM_DEPTH = 64;
   localparam int MAX_WAIT  = 7;
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_t;
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word array, no reset (contents preloaded externally).
//   clock : rising-edge clock
//   we    : write enable, writes wdata to mem[addr]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data of mem[addr] (old contents on a write)
module mem_array #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: four-phase req/ack memory slave with wait states and write protection.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   req, we, addr, wdata : initiator command, sampled when req is seen in IDLE
//   ack   : access complete, held until req drops; rdata/err valid while high
//   rdata : read data (unchanged by writes)
//   err   : write to an address below WP_LIMIT was rejected
//   busy  : responder not idle
//   rd_count, wr_count : saturating access counters, present only with MEM_RESPONDER_STATS_EN
module mem_responder import mem_pkg::*; #(
   parameter int WIDTH       = WORD_W,
   parameter int DEPTH       = MEM_DEPTH,
   parameter int WAIT_CYCLES = 2,
   parameter int WP_LIMIT    = 20
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic              ack,
   output logic [WIDTH-1:0]  rdata,
   output logic              err,
   output logic              busy
`ifdef MEM_RESPONDER_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);
   state_t            state, nxt;
   logic [2:0]        cnt, cnt_nxt;
   logic              cmd_we, prot, done, arr_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [WIDTH-1:0]  cmd_wdata, arr_rdata;
   // ACCESS takes two cycles: cnt=0 issues the array operation, cnt=1 captures the
   // synchronous read result, giving the WAIT_CYCLES+2 edge ack latency.
   assign prot   = cmd_we && (32'(cmd_addr) < WP_LIMIT);
   assign done   = (state == ACCESS) && (cnt == 3'd1);
   assign arr_we = (state == ACCESS) && (cnt == 3'd0) && cmd_we && !prot;
   assign ack    = (state == HOLD);
   assign busy   = (state != IDLE);
   mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(ADDR_W)) u_array (
      .clock(clock),
      .we(arr_we),
      .addr(cmd_addr),
      .wdata(cmd_wdata),
      .rdata(arr_rdata)
   );
   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      case (state)
         IDLE: if (req) begin
            nxt     = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            cnt_nxt = 3'd0;
         end
         WAIT: begin
            nxt     = (cnt == 3'(WAIT_CYCLES - 1)) ? ACCESS : WAIT;
            cnt_nxt = (cnt == 3'(WAIT_CYCLES - 1)) ? 3'd0 : cnt + 3'd1;
         end
         ACCESS: begin
            nxt     = (cnt == 3'd1) ? HOLD : ACCESS;
            cnt_nxt = (cnt == 3'd1) ? 3'd0 : 3'd1;
         end
         HOLD: nxt = req ? HOLD : IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         rdata     <= '0;
         err       <= 1'b0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req) begin
            cmd_we    <= we;
            cmd_addr  <= addr;
            cmd_wdata <= wdata;
         end
         if (done) begin
            err <= prot;
            if (!cmd_we) rdata <= arr_rdata;
         end
      end
   end
`ifdef MEM_RESPONDER_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if (done) begin
         if (!cmd_we) rd_count <= sat_inc(rd_count);
         else if (!prot) wr_count <= sat_inc(wr_count);
      end
   end
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_mem_responder;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
   logic [5:0] addr_a = '0, addr_b = '0;
   logic [11:0] wdata_a = '0, wdata_b = '0;
   logic ack_a, err_a, busy_a, ack_b, err_b, busy_b;
   logic [11:0] rdata_a, rdata_b;
`ifdef MEM_RESPONDER_STATS_EN
   logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif
   int vectors = 0;
   int miscompares = 0;
   logic [11:0] ref_mem [2][64];
   logic [11:0] ref_rd [2];
   int ref_rc [2];
   int ref_wc [2];

   always #5 clock = ~clock;

   mem_responder #(.WAIT_CYCLES(2)) dut_a (
      .clock(clock), .reset_n(reset_n), .req(req_a), .we(we_a), .addr(addr_a),
      .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a), .err(err_a), .busy(busy_a)
`ifdef MEM_RESPONDER_STATS_EN
      , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
   );
   mem_responder #(.WAIT_CYCLES(0)) dut_b (
      .clock(clock), .reset_n(reset_n), .req(req_b), .we(we_b), .addr(addr_b),
      .wdata(wdata_b), .ack(ack_b), .rdata(rdata_b), .err(err_b), .busy(busy_b)
`ifdef MEM_RESPONDER_STATS_EN
      , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
   );

   function automatic logic ackv(input int s);
      return (s != 0) ? ack_b : ack_a;
   endfunction
   function automatic logic errv(input int s);
      return (s != 0) ? err_b : err_a;
   endfunction
   function automatic logic busyv(input int s);
      return (s != 0) ? busy_b : busy_a;
   endfunction
   function automatic logic [11:0] rdv(input int s);
      return (s != 0) ? rdata_b : rdata_a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int s, input logic r, input logic w, input logic [5:0] a, input logic [11:0] d);
      if (s != 0) begin
         req_b = r; we_b = w; addr_b = a; wdata_b = d;
      end else begin
         req_a = r; we_a = w; addr_a = a; wdata_a = d;
      end
   endtask

   // One complete handshake; hold_extra keeps req high for extra cycles after ack.
   task automatic access(input int s, input logic w, input logic [5:0] a, input logic [11:0] d, input int hold_extra);
      int n;
      int lat;
      logic e;
      lat = (s != 0) ? 2 : 4;
      @(negedge clock);
      drive(s, 1'b1, w, a, d);
      @(posedge clock);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!ackv(s) && n < 20);
      check($sformatf("latency_s%0d_a%0d", s, a), n, lat);
      e = w && (a < 6'd20);
      if (w && !e) ref_mem[s][a] = d;
      if (!w) ref_rd[s] = ref_mem[s][a];
      if (!w) ref_rc[s]++;
      else if (!e) ref_wc[s]++;
      check($sformatf("rdata_s%0d_a%0d", s, a), rdv(s), ref_rd[s]);
      check($sformatf("err_s%0d_a%0d", s, a), errv(s), e);
      check($sformatf("busy_ack_s%0d", s), busyv(s), 1'b1);
      repeat (hold_extra) begin
         @(posedge clock);
         #1;
         check($sformatf("hold_ack_s%0d", s), ackv(s), 1'b1);
         check($sformatf("hold_rdata_s%0d", s), rdv(s), ref_rd[s]);
      end
      @(negedge clock);
      drive(s, 1'b0, w, a, d);
      @(posedge clock);
      #1;
      check($sformatf("idle_busy_s%0d", s), busyv(s), 1'b0);
      check($sformatf("idle_ack_s%0d", s), ackv(s), 1'b0);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 64; i++) ref_mem[s][i] = 12'($urandom);
         ref_rd[s] = '0;
         ref_rc[s] = 0;
         ref_wc[s] = 0;
      end
      ref_mem[0][11] = 12'h415;
      ref_mem[1][20] = 12'h006;
      for (int i = 0; i < 64; i++) begin
         dut_a.u_array.mem[i] = ref_mem[0][i];
         dut_b.u_array.mem[i] = ref_mem[1][i];
      end
      repeat (3) @(posedge clock);
      #1;
      check("rst_ack", ack_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_err", err_a, 1'b0);
      check("rst_rdata", rdata_a, 12'h000);
      check("rst_rdata_b", rdata_b, 12'h000);
      @(negedge clock);
      reset_n = 1'b1;

      access(0, 1'b1, 6'd24, 12'h00D, 0);
      access(0, 1'b0, 6'd24, 12'h000, 0);
      check("read24_value", rdata_a, 12'h00D);
      access(0, 1'b1, 6'd11, 12'hFFF, 0);
      check("prot_err", err_a, 1'b1);
      access(0, 1'b0, 6'd11, 12'h000, 0);
      check("read11_value", rdata_a, 12'h415);
      access(1, 1'b0, 6'd20, 12'h000, 0);
      check("read20_value_b", rdata_b, 12'h006);
      access(0, 1'b0, 6'd24, 12'h000, 5);
      access(0, 1'b1, 6'd19, 12'h123, 0);

      @(negedge clock);
      drive(0, 1'b1, 1'b1, 6'd30, 12'hABC);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("wrst_ack", ack_a, 1'b0);
      check("wrst_busy", busy_a, 1'b0);
      check("wrst_err", err_a, 1'b0);
      check("wrst_rdata", rdata_a, 12'h000);
      ref_rd[0] = '0;
      ref_rd[1] = '0;
      ref_rc[0] = 0; ref_rc[1] = 0;
      ref_wc[0] = 0; ref_wc[1] = 0;
      drive(0, 1'b0, 1'b0, 6'd0, 12'h000);
      @(negedge clock);
      reset_n = 1'b1;
      access(0, 1'b0, 6'd30, 12'h000, 0);

      access(0, 1'b0, 6'd24, 12'h000, 0);
      access(0, 1'b0, 6'd11, 12'h000, 0);
      access(0, 1'b1, 6'd40, 12'h5A5, 0);
      access(0, 1'b1, 6'd50, 12'h3C3, 0);
      access(0, 1'b1, 6'd5, 12'h777, 0);
`ifdef MEM_RESPONDER_STATS_EN
      check("stats_rd", rdc_a, 16'd3);
      check("stats_wr", wrc_a, 16'd2);
`endif

      for (int k = 0; k < 40; k++) begin
         access(int'($urandom_range(0, 1)), 1'($urandom), 6'($urandom), 12'($urandom), int'($urandom_range(0, 2)));
      end
`ifdef MEM_RESPONDER_STATS_EN
      check("final_rd_a", rdc_a, 32'(ref_rc[0]));
      check("final_wr_a", wrc_a, 32'(ref_wc[0]));
      check("final_rd_b", rdc_b, 32'(ref_rc[1]));
      check("final_wr_b", wrc_b, 32'(ref_wc[1]));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
